// File: rtl/wav_net_pkg.sv
// Shared constants and header layout for the audio-to-UDP frame packer.
package wav_net_pkg;

   localparam int UDP_LENGTH_BIT     = 7680;
   localparam int HEADER_LENGTH_BIT  = 96;
   localparam int PAYLOAD_LENGTH_BIT = UDP_LENGTH_BIT - HEADER_LENGTH_BIT;
   localparam int SAMPLES_PER_FRAME  = 474;
   localparam int UDP_LENGTH_BYTES   = UDP_LENGTH_BIT / 8;
   localparam int IDX_W              = 9;

   localparam logic [31:0] MAGIC    = 32'h5741_5645;
   localparam logic [7:0]  CMD_STOP = 8'h00;
   localparam logic [7:0]  CMD_RUN  = 8'h01;

   typedef logic [IDX_W-1:0] fill_idx_t;

   typedef struct packed {
      logic [31:0] magic;
      logic [31:0] seq;
      logic [15:0] count;
      logic [15:0] rsvd;
   } frame_hdr_t;

   function automatic frame_hdr_t make_hdr(input logic [31:0] seq);
      frame_hdr_t h;
      h.magic = MAGIC;
      h.seq   = seq;
      h.count = 16'(SAMPLES_PER_FRAME);
      h.rsvd  = 16'h0000;
      return h;
   endfunction

endpackage

// File: rtl/wav_net_if.sv
// Sample input, UDP send handshake and UDP receive control channel.
interface wav_net_if;
   import wav_net_pkg::*;

   logic [15:0]               wav_in_data;
   logic                      wav_wren;
   logic                      udp_send_data_valid;
   logic                      udp_send_data_ready;
   logic [UDP_LENGTH_BIT-1:0] udp_send_data;
   logic [15:0]               udp_send_data_length;
   logic                      udp_rec_data_valid;
   logic [7:0]                udp_rec_rdata;
   logic [15:0]               udp_rec_data_length;

   modport master (
      output wav_in_data, wav_wren, udp_send_data_ready,
             udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length,
      input  udp_send_data_valid, udp_send_data, udp_send_data_length
   );

   modport slave (
      input  wav_in_data, wav_wren, udp_send_data_ready,
             udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length,
      output udp_send_data_valid, udp_send_data, udp_send_data_length
   );

endinterface

// File: rtl/wav_sample_packer.sv
// Writes 16-bit samples MSB-first into the payload register and flags the
// write that completes a frame; payload_next already includes that sample.
module wav_sample_packer
   import wav_net_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr,
   input  logic                          clr,
   input  logic [15:0]                   data,
   output logic [PAYLOAD_LENGTH_BIT-1:0] payload_next,
   output logic                          frame_done
);

   localparam fill_idx_t LAST_IDX = fill_idx_t'(SAMPLES_PER_FRAME - 1);

   fill_idx_t                     index;
   logic [PAYLOAD_LENGTH_BIT-1:0] payload;

   assign frame_done = wr && (index == LAST_IDX);

   always_comb begin
      payload_next = payload;
      payload_next[PAYLOAD_LENGTH_BIT - 1 - 16*int'(index) -: 16] = data;
   end

   // The payload is never cleared on wrap: the next frame overwrites every slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index   <= '0;
         payload <= '0;
      end else begin
         if (wr)
            payload <= payload_next;
         if (clr)
            index <= '0;
         else if (wr)
            index <= frame_done ? '0 : index + fill_idx_t'(1);
      end
   end

endmodule

// File: rtl/wav_net_top.sv
// Audio sample stream to fixed 960-byte UDP frames with a one-byte
// pause/resume control channel on the UDP receive side.
module wav_net_top
   import wav_net_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   wav_net_if.slave bus
);

   logic                          stream_en;
   logic                          first_seen;
   logic                          cmd_strobe;
   logic                          clr_fill;
   logic                          wr;
   logic                          frame_done;
   logic                          handshake;
   logic                          send_valid;
   logic [31:0]                   seq;
   logic [PAYLOAD_LENGTH_BIT-1:0] payload_next;
   logic [UDP_LENGTH_BIT-1:0]     send_data;
   logic                          unused_rec_len;

   assign cmd_strobe = bus.udp_rec_data_valid && !first_seen;
   assign clr_fill   = cmd_strobe && (bus.udp_rec_rdata == CMD_STOP);
   assign wr         = bus.wav_wren && stream_en;
   assign handshake  = send_valid && bus.udp_send_data_ready;

   wav_sample_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .wr           (wr),
      .clr          (clr_fill),
      .data         (bus.wav_in_data),
      .payload_next (payload_next),
      .frame_done   (frame_done)
   );

   // Only the first byte of each received packet is a command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_seen <= 1'b0;
         stream_en  <= 1'b1;
      end else begin
         first_seen <= bus.udp_rec_data_valid;
         if (cmd_strobe) begin
            if (bus.udp_rec_rdata == CMD_STOP)
               stream_en <= 1'b0;
            else if (bus.udp_rec_rdata == CMD_RUN)
               stream_en <= 1'b1;
         end
      end
   end

   // seq advances even when the frame is dropped so the host sees the gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq        <= '0;
         send_valid <= 1'b0;
         send_data  <= '0;
      end else begin
         if (frame_done)
            seq <= seq + 32'd1;
         if (frame_done && (!send_valid || handshake)) begin
            send_data  <= {make_hdr(seq), payload_next};
            send_valid <= 1'b1;
         end else if (handshake) begin
            send_valid <= 1'b0;
         end
      end
   end

   assign bus.udp_send_data_valid  = send_valid;
   assign bus.udp_send_data        = send_data;
   assign bus.udp_send_data_length = 16'(UDP_LENGTH_BYTES);

   assign unused_rec_len = ^bus.udp_rec_data_length;

endmodule

// File: tb/tb_wav_net_top.sv
// Directed bench for wav_net_top: frame build, backpressure, drop, control, reset.
module tb_wav_net_top;
   import wav_net_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wav_net_if bus();

   wav_net_top dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [7679:0] cap_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sample_of(input logic [7679:0] f, input int k);
      return f[7583 - 16*k -: 16];
   endfunction

   task automatic check_frame(input string tag, input logic [7679:0] f,
                              input logic [31:0] exp_seq, input logic [15:0] first);
      check({tag, "_magic_seq"}, f[7679:7616], {32'h5741_5645, exp_seq});
      check({tag, "_cnt_rsvd"}, 64'(f[7615:7584]), 64'h01DA_0000);
      check({tag, "_s0"},   64'(sample_of(f, 0)),   64'(first));
      check({tag, "_s237"}, 64'(sample_of(f, 237)), 64'(first + 16'd237));
      check({tag, "_s473"}, 64'(sample_of(f, 473)), 64'(first + 16'd473));
   endtask

   task automatic stream(input logic [15:0] start, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.wav_wren    = 1'b1;
         bus.wav_in_data = start + 16'(i);
         if (gap > 0) begin
            @(negedge clk);
            bus.wav_wren = 1'b0;
            repeat (gap - 1) @(negedge clk);
         end
      end
      @(negedge clk);
      bus.wav_wren = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.udp_rec_data_valid = 1'b1;
         bus.udp_rec_rdata      = (i == 0) ? b0 : b1;
      end
      @(negedge clk);
      bus.udp_rec_data_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Handshake monitor: looks just after the bench drives inputs, before the edge.
   always begin
      @(negedge clk);
      #2;
      if (bus.udp_send_data_valid === 1'b1 && bus.udp_send_data_ready === 1'b1)
         cap_q.push_back(bus.udp_send_data);
   end

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int bad;
      logic [7679:0] f;

      rst = 1'b1;
      bus.wav_wren = 1'b0;
      bus.wav_in_data = '0;
      bus.udp_send_data_ready = 1'b0;
      bus.udp_rec_data_valid = 1'b0;
      bus.udp_rec_rdata = '0;
      bus.udp_rec_data_length = 16'd3;
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(bus.udp_send_data_valid), 64'd0);
      check("rst_data",  64'(|bus.udp_send_data), 64'd0);
      check("rst_len",   64'(bus.udp_send_data_length), 64'd960);
      rst = 1'b0;

      // 1: first frame, valid the cycle after sample 473
      stream(16'd0, 473, 3);
      check("t1_valid_early", 64'(bus.udp_send_data_valid), 64'd0);
      stream(16'd473, 1, 0);
      check("t1_valid", 64'(bus.udp_send_data_valid), 64'd1);
      check_frame("t1", bus.udp_send_data, 32'd0, 16'd0);
      check("t1_len", 64'(bus.udp_send_data_length), 64'd960);

      // 2: backpressure, frame 1 dropped, single handshake, frame 2 has seq 2
      stream(16'd474, 474, 1);
      check("t2_hold_valid", 64'(bus.udp_send_data_valid), 64'd1);
      check_frame("t2_hold", bus.udp_send_data, 32'd0, 16'd0);
      bus.udp_send_data_ready = 1'b1;
      @(negedge clk);
      bus.udp_send_data_ready = 1'b0;
      check("t2_drop_valid", 64'(bus.udp_send_data_valid), 64'd0);
      check("t2_hs_count", 64'(cap_q.size()), 64'd1);
      if (cap_q.size() > 0)
         check_frame("t2_hs", cap_q[0], 32'd0, 16'd0);
      cap_q.delete();
      stream(16'd948, 474, 1);
      check("t2_next_valid", 64'(bus.udp_send_data_valid), 64'd1);
      check_frame("t2_next", bus.udp_send_data, 32'd2, 16'd948);

      // 3: ready held high, six back-to-back frames
      do_reset();
      bus.udp_send_data_ready = 1'b1;
      @(negedge clk);
      cap_q.delete();
      stream(16'd0, 2844, 0);
      repeat (3) @(negedge clk);
      check("t3_count", 64'(cap_q.size()), 64'd6);
      check("t3_valid_idle", 64'(bus.udp_send_data_valid), 64'd0);
      bad = 0;
      for (int j = 0; j < cap_q.size() && j < 6; j++) begin
         f = cap_q[j];
         check($sformatf("t3_seq%0d", j), 64'(f[7647:7616]), 64'(j));
         for (int k = 0; k < 474; k++)
            if (sample_of(f, k) !== 16'(474*j + k)) bad++;
      end
      check("t3_samples", 64'(bad), 64'd0);

      // 4: stop mid-frame, ignored samples and codes, resume
      cap_q.delete();
      stream(16'h5000, 50, 1);
      send_pkt(8'h00, 8'h01, 3);
      stream(16'h6000, 100, 1);
      send_pkt(8'h7F, 8'h01, 2);
      stream(16'h6100, 474, 1);
      check("t4_stopped_none", 64'(cap_q.size()), 64'd0);
      check("t4_stopped_valid", 64'(bus.udp_send_data_valid), 64'd0);
      send_pkt(8'h01, 8'h00, 2);
      stream(16'h1000, 474, 1);
      repeat (2) @(negedge clk);
      check("t4_count", 64'(cap_q.size()), 64'd1);
      if (cap_q.size() > 0)
         check_frame("t4", cap_q[0], 32'd6, 16'h1000);

      // 5: reset mid-frame
      bus.udp_send_data_ready = 1'b0;
      cap_q.delete();
      stream(16'h2000, 200, 1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_rst_valid", 64'(bus.udp_send_data_valid), 64'd0);
      check("t5_rst_data",  64'(|bus.udp_send_data), 64'd0);
      check("t5_rst_len",   64'(bus.udp_send_data_length), 64'd960);
      @(negedge clk);
      rst = 1'b0;
      stream(16'h3000, 474, 1);
      check("t5_valid", 64'(bus.udp_send_data_valid), 64'd1);
      check_frame("t5", bus.udp_send_data, 32'd0, 16'h3000);

      // 6: completion on the same edge as the handshake of the pending frame
      cap_q.delete();
      stream(16'h4000, 473, 1);
      @(negedge clk);
      bus.wav_wren = 1'b1;
      bus.wav_in_data = 16'h41D9;
      bus.udp_send_data_ready = 1'b1;
      @(negedge clk);
      bus.wav_wren = 1'b0;
      bus.udp_send_data_ready = 1'b0;
      check("t6_valid", 64'(bus.udp_send_data_valid), 64'd1);
      check_frame("t6_new", bus.udp_send_data, 32'd1, 16'h4000);
      check("t6_hs_count", 64'(cap_q.size()), 64'd1);
      if (cap_q.size() > 0)
         check_frame("t6_old", cap_q[0], 32'd0, 16'h3000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
